// File: rtl/vdp_cpu_port_if.sv
// CPU port bus bundle for the VDP: CPU I/O strobes, VRAM request/ack,
// register-file write, renderer status events and interrupt output.
interface vdp_cpu_port_if;
   // CPU side
   logic       rd_tick;
   logic       wr_tick;
   logic       port_sel;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       busy;
   // VRAM arbiter side
   logic        vram_req;
   logic        vram_we;
   logic [13:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic        vram_ack;
   logic [7:0]  vram_rdata;
   // register file side
   logic       reg_we;
   logic [2:0] reg_num;
   logic [7:0] reg_data;
   // renderer status events
   logic       frame_tick;
   logic       coll_tick;
   logic       fifth_tick;
   logic [4:0] fifth_num;
   // interrupt and debug
   logic       int_n;
   logic       dbg_state;   // control FSM: 0 = FIRST, 1 = SECOND

   // Port-side view (the VDP CPU port itself)
   modport slave (
      input  rd_tick, wr_tick, port_sel, wdata,
      output rdata, busy,
      output vram_req, vram_we, vram_addr, vram_wdata,
      input  vram_ack, vram_rdata,
      output reg_we, reg_num, reg_data,
      input  frame_tick, coll_tick, fifth_tick, fifth_num,
      output int_n, dbg_state
   );

   // Environment-side view (CPU decode, arbiter, renderer)
   modport master (
      output rd_tick, wr_tick, port_sel, wdata,
      input  rdata, busy,
      input  vram_req, vram_we, vram_addr, vram_wdata,
      output vram_ack, vram_rdata,
      input  reg_we, reg_num, reg_data,
      output frame_tick, coll_tick, fifth_tick, fifth_num,
      input  int_n, dbg_state
   );
endinterface

// File: rtl/vdp_cpu_port.sv
// VDP CPU port: two-byte control protocol, auto-incrementing 14-bit VRAM
// address with read-ahead buffer, register writes, status byte and interrupt.
//
// VRAM handshake: vram_req is raised the cycle after the initiating tick and
// vram_req/vram_we/vram_addr/vram_wdata hold steady until the cycle in which
// vram_ack=1 (the transfer cycle; read data is valid then). vram_req drops the
// following cycle. busy mirrors vram_req; data-port ticks seen while busy are
// dropped.
module vdp_cpu_port (
   input  logic clk,
   input  logic reset,
   vdp_cpu_port_if.slave bus
);

   typedef enum logic {ST_FIRST = 1'b0, ST_SECOND = 1'b1} ctl_state_t;

   ctl_state_t  state_q;
   logic [7:0]  latch_q;
   logic [13:0] addr_q;
   logic [7:0]  rbuf_q;
   logic        vram_req_q, vram_we_q;
   logic [13:0] vram_addr_q;
   logic [7:0]  vram_wdata_q;
   logic        reg_we_q;
   logic [2:0]  reg_num_q;
   logic [7:0]  reg_data_q;
   logic        f_q, c_q, s5_q, ie_q, int_n_q;
   logic        f_d, c_d, s5_d, ie_d;
   logic [4:0]  fifth_q, fifth_d;

   logic        ctl_wr, data_wr, data_rd, stat_rd, data_acc, reg1_wr;
   logic [13:0] new_addr;

   assign ctl_wr   = bus.wr_tick & bus.port_sel;
   assign data_wr  = bus.wr_tick & ~bus.port_sel;
   assign data_rd  = bus.rd_tick & ~bus.port_sel;
   assign stat_rd  = bus.rd_tick & bus.port_sel;
   assign data_acc = data_wr | data_rd | stat_rd;
   assign new_addr = {bus.wdata[5:0], latch_q};
   assign reg1_wr  = ctl_wr & (state_q == ST_SECOND) & bus.wdata[7] &
                     (bus.wdata[2:0] == 3'd1);

   // Status flag and interrupt-enable next state; set events beat a clearing read
   always_comb begin
      f_d     = f_q;
      c_d     = c_q;
      s5_d    = s5_q;
      fifth_d = fifth_q;
      ie_d    = reg1_wr ? latch_q[5] : ie_q;
      if (stat_rd) begin
         f_d  = 1'b0;
         c_d  = 1'b0;
         s5_d = 1'b0;
      end
      if (bus.frame_tick) f_d = 1'b1;
      if (bus.coll_tick)  c_d = 1'b1;
      if (bus.fifth_tick) begin
         s5_d = 1'b1;
         if (!s5_q) fifth_d = bus.fifth_num;
      end
   end

   // Status register, interrupt enable and the registered interrupt output
   always_ff @(posedge clk) begin
      if (reset) begin
         f_q     <= 1'b0;
         c_q     <= 1'b0;
         s5_q    <= 1'b0;
         fifth_q <= 5'd0;
         ie_q    <= 1'b0;
         int_n_q <= 1'b1;
      end else begin
         f_q     <= f_d;
         c_q     <= c_d;
         s5_q    <= s5_d;
         fifth_q <= fifth_d;
         ie_q    <= ie_d;
         int_n_q <= ~(f_d & ie_d);
      end
   end

   // Control-byte FSM, address counter, read-ahead buffer and VRAM/register requests
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FIRST;
         latch_q      <= 8'd0;
         addr_q       <= 14'd0;
         rbuf_q       <= 8'd0;
         vram_req_q   <= 1'b0;
         vram_we_q    <= 1'b0;
         vram_addr_q  <= 14'd0;
         vram_wdata_q <= 8'd0;
         reg_we_q     <= 1'b0;
         reg_num_q    <= 3'd0;
         reg_data_q   <= 8'd0;
      end else begin
         reg_we_q <= 1'b0;

         // Transfer completes in the ack cycle; reads refill the buffer
         if (vram_req_q && bus.vram_ack) begin
            vram_req_q <= 1'b0;
            if (!vram_we_q) rbuf_q <= bus.vram_rdata;
         end

         if (data_acc) begin
            state_q <= ST_FIRST;
         end else if (ctl_wr) begin
            if (state_q == ST_FIRST) begin
               latch_q <= bus.wdata;
               state_q <= ST_SECOND;
            end else begin
               state_q <= ST_FIRST;
               if (bus.wdata[7]) begin
                  reg_we_q   <= 1'b1;
                  reg_num_q  <= bus.wdata[2:0];
                  reg_data_q <= latch_q;
               end else if (bus.wdata[6] || vram_req_q) begin
                  // write setup, or a read setup that cannot prefetch right now
                  addr_q <= new_addr;
               end else begin
                  vram_req_q  <= 1'b1;
                  vram_we_q   <= 1'b0;
                  vram_addr_q <= new_addr;
                  addr_q      <= new_addr + 14'd1;
               end
            end
         end

         if (data_wr && !vram_req_q) begin
            vram_req_q   <= 1'b1;
            vram_we_q    <= 1'b1;
            vram_addr_q  <= addr_q;
            vram_wdata_q <= bus.wdata;
            rbuf_q       <= bus.wdata;
            addr_q       <= addr_q + 14'd1;
         end

         if (data_rd && !vram_req_q) begin
            vram_req_q  <= 1'b1;
            vram_we_q   <= 1'b0;
            vram_addr_q <= addr_q;
            addr_q      <= addr_q + 14'd1;
         end
      end
   end

   assign bus.rdata      = bus.port_sel ? {f_q, c_q, s5_q, fifth_q} : rbuf_q;
   assign bus.busy       = vram_req_q;
   assign bus.vram_req   = vram_req_q;
   assign bus.vram_we    = vram_we_q;
   assign bus.vram_addr  = vram_addr_q;
   assign bus.vram_wdata = vram_wdata_q;
   assign bus.reg_we     = reg_we_q;
   assign bus.reg_num    = reg_num_q;
   assign bus.reg_data   = reg_data_q;
   assign bus.int_n      = int_n_q;
   assign bus.dbg_state  = (state_q == ST_SECOND);

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port: register writes, address wrap, prefetch
// reads, control toggle reset, status races, busy drop and mid-transfer reset.
module tb_vdp_cpu_port;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   vdp_cpu_port_if bus ();

   vdp_cpu_port dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // advance one clock; inputs are captured at the edge, outputs sampled 1ns later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ctl_wr(input logic [7:0] d);
      bus.port_sel = 1'b1;
      bus.wdata    = d;
      bus.wr_tick  = 1'b1;
      step();
      bus.wr_tick  = 1'b0;
   endtask

   task automatic data_wr(input logic [7:0] d);
      bus.port_sel = 1'b0;
      bus.wdata    = d;
      bus.wr_tick  = 1'b1;
      step();
      bus.wr_tick  = 1'b0;
   endtask

   task automatic rd(input logic sel);
      bus.port_sel = sel;
      bus.rd_tick  = 1'b1;
      step();
      bus.rd_tick  = 1'b0;
   endtask

   // acknowledge the outstanding VRAM request for one cycle
   task automatic ack(input logic [7:0] d);
      bus.vram_ack   = 1'b1;
      bus.vram_rdata = d;
      step();
      bus.vram_ack   = 1'b0;
      bus.vram_rdata = 8'h00;
   endtask

   task automatic peek(input logic sel);
      bus.port_sel = sel;
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset          = 1'b1;
      bus.rd_tick    = 1'b0;
      bus.wr_tick    = 1'b0;
      bus.port_sel   = 1'b0;
      bus.wdata      = 8'h00;
      bus.vram_ack   = 1'b0;
      bus.vram_rdata = 8'h00;
      bus.frame_tick = 1'b0;
      bus.coll_tick  = 1'b0;
      bus.fifth_tick = 1'b0;
      bus.fifth_num  = 5'd0;
      step();
      step();
      reset = 1'b0;
      step();

      // reset state
      peek(1'b0);
      chk("rst_rbuf", {8'h0, bus.rdata}, 16'h0000);
      peek(1'b1);
      chk("rst_status", {8'h0, bus.rdata}, 16'h0000);
      chk("rst_int_n", {15'h0, bus.int_n}, 16'h0001);
      chk("rst_busy", {15'h0, bus.busy}, 16'h0000);
      chk("rst_vram_req", {15'h0, bus.vram_req}, 16'h0000);
      chk("rst_fsm", {15'h0, bus.dbg_state}, 16'h0000);

      // register write: reg1 <= 0xE0, enables interrupt
      ctl_wr(8'hE0);
      chk("reg_fsm_second", {15'h0, bus.dbg_state}, 16'h0001);
      ctl_wr(8'h81);
      chk("reg_we_pulse", {15'h0, bus.reg_we}, 16'h0001);
      chk("reg_num", {13'h0, bus.reg_num}, 16'h0001);
      chk("reg_data", {8'h0, bus.reg_data}, 16'h00E0);
      chk("reg_fsm_first", {15'h0, bus.dbg_state}, 16'h0000);
      step();
      chk("reg_we_drop", {15'h0, bus.reg_we}, 16'h0000);
      chk("reg_data_hold", {8'h0, bus.reg_data}, 16'h00E0);
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      chk("int_asserted", {15'h0, bus.int_n}, 16'h0000);
      peek(1'b1);
      chk("status_f_set", {8'h0, bus.rdata}, 16'h0080);
      rd(1'b1);
      chk("status_f_clr", {8'h0, bus.rdata}, 16'h0000);
      chk("int_released", {15'h0, bus.int_n}, 16'h0001);

      // write with wrap at 0x3FFF
      ctl_wr(8'hFF);
      ctl_wr(8'h7F);
      chk("wsetup_no_req", {15'h0, bus.vram_req}, 16'h0000);
      data_wr(8'hAA);
      chk("wr1_req", {15'h0, bus.vram_req}, 16'h0001);
      chk("wr1_we", {15'h0, bus.vram_we}, 16'h0001);
      chk("wr1_addr", {2'b0, bus.vram_addr}, 16'h3FFF);
      chk("wr1_data", {8'h0, bus.vram_wdata}, 16'h00AA);
      chk("wr1_busy", {15'h0, bus.busy}, 16'h0001);
      ack(8'h00);
      chk("wr1_req_drop", {15'h0, bus.vram_req}, 16'h0000);
      data_wr(8'h55);
      chk("wr2_addr_wrap", {2'b0, bus.vram_addr}, 16'h0000);
      chk("wr2_data", {8'h0, bus.vram_wdata}, 16'h0055);
      ack(8'h00);
      peek(1'b0);
      chk("rbuf_after_wr", {8'h0, bus.rdata}, 16'h0055);
      rd(1'b0);
      chk("rd_after_wr_addr", {2'b0, bus.vram_addr}, 16'h0001);
      chk("rd_after_wr_we", {15'h0, bus.vram_we}, 16'h0000);
      ack(8'h99);
      peek(1'b0);
      chk("rbuf_ack_load", {8'h0, bus.rdata}, 16'h0099);

      // read setup with prefetch at 0x1000
      ctl_wr(8'h00);
      ctl_wr(8'h10);
      chk("rsetup_req", {15'h0, bus.vram_req}, 16'h0001);
      chk("rsetup_we", {15'h0, bus.vram_we}, 16'h0000);
      chk("rsetup_addr", {2'b0, bus.vram_addr}, 16'h1000);
      ack(8'h3C);
      peek(1'b0);
      chk("prefetch_data", {8'h0, bus.rdata}, 16'h003C);
      rd(1'b0);
      chk("rd_next_addr", {2'b0, bus.vram_addr}, 16'h1001);
      ack(8'h47);
      rd(1'b0);
      chk("rd_addr_1002", {2'b0, bus.vram_addr}, 16'h1002);
      ack(8'h00);

      // control toggle reset by a status read
      ctl_wr(8'h34);
      rd(1'b1);
      chk("toggle_fsm_first", {15'h0, bus.dbg_state}, 16'h0000);
      ctl_wr(8'h00);
      ctl_wr(8'h40);
      chk("toggle_no_req", {15'h0, bus.vram_req}, 16'h0000);
      data_wr(8'h11);
      chk("toggle_addr", {2'b0, bus.vram_addr}, 16'h0000);
      ack(8'h00);

      // status race: set and clearing read in the same cycle
      bus.frame_tick = 1'b1;
      step();
      bus.port_sel = 1'b1;
      bus.rd_tick  = 1'b1;
      #1;
      chk("race_rdata_f", {15'h0, bus.rdata[7]}, 16'h0001);
      step();
      bus.rd_tick    = 1'b0;
      bus.frame_tick = 1'b0;
      chk("race_f_kept", {15'h0, bus.rdata[7]}, 16'h0001);
      chk("race_int_n", {15'h0, bus.int_n}, 16'h0000);
      bus.rd_tick = 1'b1;
      #1;
      chk("race_second_rd", {15'h0, bus.rdata[7]}, 16'h0001);
      step();
      bus.rd_tick = 1'b0;
      chk("race_f_cleared", {15'h0, bus.rdata[7]}, 16'h0000);

      // collision and fifth-sprite capture; second fifth event does not overwrite
      bus.coll_tick  = 1'b1;
      bus.fifth_tick = 1'b1;
      bus.fifth_num  = 5'h0B;
      step();
      bus.coll_tick  = 1'b0;
      bus.fifth_num  = 5'h05;
      step();
      bus.fifth_tick = 1'b0;
      chk("status_c_5s", {8'h0, bus.rdata}, 16'h006B);
      rd(1'b1);
      chk("status_fifth_kept", {8'h0, bus.rdata}, 16'h000B);

      // busy drop: second write while the first is unacked
      data_wr(8'h22);
      chk("busy_wr_addr", {2'b0, bus.vram_addr}, 16'h0001);
      data_wr(8'h33);
      chk("drop_addr", {2'b0, bus.vram_addr}, 16'h0001);
      chk("drop_wdata", {8'h0, bus.vram_wdata}, 16'h0022);
      peek(1'b0);
      chk("drop_rbuf", {8'h0, bus.rdata}, 16'h0022);
      ack(8'h00);
      data_wr(8'h44);
      chk("after_drop_addr", {2'b0, bus.vram_addr}, 16'h0002);

      // reset while the request is outstanding
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_req", {15'h0, bus.vram_req}, 16'h0000);
      chk("mid_rst_busy", {15'h0, bus.busy}, 16'h0000);
      chk("mid_rst_vaddr", {2'b0, bus.vram_addr}, 16'h0000);
      peek(1'b0);
      chk("mid_rst_rbuf", {8'h0, bus.rdata}, 16'h0000);
      peek(1'b1);
      chk("mid_rst_status", {8'h0, bus.rdata}, 16'h0000);
      data_wr(8'h5A);
      chk("post_rst_addr", {2'b0, bus.vram_addr}, 16'h0000);
      ack(8'h00);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vdp_cpu_port.md
# vdp_cpu_port

CPU-facing port of the nouveau VDP, decoded at I/O 0x80 (data) and 0x81 (control). It implements the TMS9918-style two-byte control protocol, a 14-bit auto-incrementing VRAM address with read-ahead buffer, register writes, and a status register with interrupt output. It sits between the Z8S180 bus decode in `top` and the VRAM arbiter and register file inside `video`. It is the responder to the CPU's I/O read/write cycles.

## Interface
- Parameters: none (VRAM address width fixed at 14).
- `clk` in 1: phi-synchronous clock; same clock and edge as the iorq tick generators.
- `reset` in 1: reset, synchronous, active-high.
- `rd_tick` in 1: one-cycle strobe, CPU read of 0x80/0x81 completing.
- `wr_tick` in 1: one-cycle strobe, CPU write of 0x80/0x81; `wdata` valid this cycle.
- `port_sel` in 1: a[0]; 0 = data port, 1 = control/status port.
- `wdata` in 8: CPU write data.
- `rdata` out 8: combinational; `port_sel`=0 gives the read-ahead buffer, 1 gives the status byte.
- `busy` out 1: a VRAM transaction is outstanding; `top` stretches wait_n with it.
- `vram_req` out 1, `vram_we` out 1, `vram_addr` out 14, `vram_wdata` out 8: VRAM request to the arbiter.
- `vram_ack` in 1, `vram_rdata` in 8: arbiter completion; read data valid in the ack cycle.
- `reg_we` out 1, `reg_num` out 3, `reg_data` out 8: one-cycle VDP register write.
- `frame_tick`, `coll_tick`, `fifth_tick` in 1 each; `fifth_num` in 5: status events from the renderer.
- `int_n` out 1: active-low interrupt request.

## Operation
- **Control write FSM:** states FIRST and SECOND.
  - In FIRST, a control write stores `wdata` in `latch` and moves to SECOND.
  - In SECOND, a control write returns to FIRST and decodes `wdata[7:6]`:
    - 1x: register write. `reg_num`=`wdata[2:0]`, `reg_data`=`latch`. If `reg_num`=1, `ie`<=`latch[5]`.
    - 00: `addr`<={`wdata[5:0]`,`latch`}, then a prefetch read at `addr`, then `addr`+1.
    - 01: `addr`<={`wdata[5:0]`,`latch`}, with no VRAM access.
  - Any data-port access or status read forces FIRST.
- **Data write:** issues a VRAM write of `wdata` at `addr`, loads `wdata` into the read-ahead buffer, then `addr`+1.
- **Data read:** `rdata` presents the current read-ahead value. On `rd_tick`, a prefetch read at `addr` is issued, then `addr`+1.
- **Address increment:** modulo 2^14 (0x3FFF -> 0x0000). The increment happens when the request is issued, not when it is acked.
- **Status byte:** {F, C, 5S, fifth[4:0]}.
  - `frame_tick` sets F. `coll_tick` sets C.
  - `fifth_tick` sets 5S and loads `fifth_num` only when 5S=0.
  - A status read `rd_tick` clears F, C and 5S; `fifth` is retained.
  - If a set event and a status read happen in the same cycle, set wins and the flag reads 1 afterwards.
- **Interrupt:** `int_n` = ~(F & `ie`).
- **VRAM handshake:**
  - `vram_req` rises the cycle after the initiating tick.
  - `vram_req`, `vram_we`, `vram_addr` and `vram_wdata` stay stable until the cycle `vram_ack`=1. `vram_req` drops the next cycle.
  - On a read ack, the read-ahead buffer <= `vram_rdata`.
  - `busy` = `vram_req`.
  - A data-port tick arriving while `busy`=1 is dropped entirely: no address change, no buffer change. Its FSM reset to FIRST still applies.
- **Reset (synchronous, mid-transaction included):** all of the following are cleared immediately, and any in-flight VRAM transaction is abandoned.
  - FSM=FIRST, `latch`=0, `addr`=0, read-ahead=0, status=0x00, `ie`=0.
  - `vram_req`=0, `vram_we`=0, `vram_addr`=0, `vram_wdata`=0.
  - `reg_we`=0, `reg_num`=0, `reg_data`=0, `busy`=0, `int_n`=1.

## Timing
- Tick at cycle T. `reg_we` pulses at T+1, with `reg_num`/`reg_data` held until the next register write.
- Tick at T gives `vram_req`=1 at T+1. With an immediate ack at T+1, `vram_req`=0 and the read-ahead is updated at T+2. The minimum transaction is 2 cycles.
- Status-flag clears from a read tick at T are visible at T+1. `rdata` during the tick cycle is the pre-clear value.
- `int_n` is registered and follows F/`ie` with 1-cycle latency.

## Test plan
- **Register write:** control writes 0xE0 then 0x81 -> `reg_we` pulse with `reg_num`=1, `reg_data`=0xE0; `ie`=1. After a `frame_tick`, `int_n`=0 next cycle.
- **Write with wrap:**
  - Control writes 0xFF, 0x7F -> `addr`=0x3FFF with no VRAM access.
  - Data writes 0xAA then 0x55 (each acked) -> VRAM writes at 0x3FFF and 0x0000.
  - A data read now returns 0x55.
- **Read setup:**
  - Control writes 0x00, 0x10 -> prefetch read at 0x1000. Ack with `vram_rdata`=0x3C.
  - Data read returns 0x3C and triggers a read at 0x1001; `addr`=0x1002.
- **Toggle reset:** control write 0x34, then a status read, then control writes 0x00, 0x40 -> `addr`=0x0000 (the 0x34 is discarded).
- **Status race:** `frame_tick` in the same cycle as a status `rd_tick` with F=1 -> returned byte has bit7=1 and F remains 1. A second read returns bit7=1, and F clears after it.
- **Busy drop / reset:** hold `vram_ack`=0 after a data write and issue another data write -> dropped and `addr` unchanged. Assert reset while `vram_req`=1 -> `vram_req`=0 and `addr`=0 next cycle.
